// File: rtl/uart_key_decoder.sv
// uart_key_decoder: turns UART bytes into one-hot direction keys queued in a small FIFO,
// with repeat holdoff, reverse-direction filtering and a turbo toggle.
module uart_key_decoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int HOLDOFF    = 650000,
    parameter int CASE_INS   = 1,
    parameter int NO_REVERSE = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    r_data,
    input  logic                          rx_empty,
    output logic                          rd_uart,
    input  logic                          key_rd,
    output logic [3:0]                    key_out,
    output logic                          key_valid,
    output logic                          turbo_button,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [7:0]                    drop_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, DECODE} state_t;

    state_t          state;
    logic [7:0]      byte_q;
    logic [3:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [23:0]     holdoff_cnt;
    logic [3:0]      last_key;
    logic [3:0]      key, opp;
    logic            ci, decode, take, pop, full, cand, push, drop;

    assign ci     = CASE_INS != 0;
    assign decode = state == DECODE;
    assign take   = state == IDLE && !rx_empty;
    assign key    = (byte_q == 8'h77 || (ci && byte_q == 8'h57)) ? 4'b0001 :
                    (byte_q == 8'h73 || (ci && byte_q == 8'h53)) ? 4'b0010 :
                    (byte_q == 8'h61 || (ci && byte_q == 8'h41)) ? 4'b0100 :
                    (byte_q == 8'h64 || (ci && byte_q == 8'h44)) ? 4'b1000 : 4'b0000;
    // up<->down and left<->right; a zero last_key yields zero, which never matches a real key
    assign opp    = {last_key[2], last_key[3], last_key[0], last_key[1]};
    assign pop    = key_rd && count != '0;
    assign full   = count == CW'(FIFO_DEPTH);
    assign cand   = decode && key != 4'b0000
                    && !(key == last_key && holdoff_cnt != '0)
                    && !(NO_REVERSE != 0 && key == opp);
    assign push   = cand && (!full || pop);
    assign drop   = cand && full && !pop;

    assign key_valid  = count != '0;
    assign key_out    = key_valid ? mem[rd_ptr] : 4'b0000;
    assign fifo_count = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rd_uart      <= 1'b0;
            byte_q       <= 8'h00;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            holdoff_cnt  <= '0;
            last_key     <= 4'b0000;
            turbo_button <= 1'b0;
            drop_count   <= 8'h00;
        end else begin
            state   <= take ? DECODE : IDLE;
            rd_uart <= take;
            if (take)
                byte_q <= r_data;
            if (decode && byte_q == 8'h20)
                turbo_button <= ~turbo_button;
            if (push) begin
                mem[wr_ptr] <= key;
                wr_ptr      <= wr_ptr + AW'(1);
                last_key    <= key;
                holdoff_cnt <= 24'(HOLDOFF);
            end else if (holdoff_cnt != '0) begin
                holdoff_cnt <= holdoff_cnt - 24'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (drop && drop_count != 8'hff)
                drop_count <= drop_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_uart_key_decoder.sv
// tb_uart_key_decoder: directed and randomized checks of uart_key_decoder against a queue-based model.
module tb_uart_key_decoder;
    localparam int DEPTH = 4;
    localparam int HOLD  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] r_data = 8'h00;
    logic       rx_empty = 1'b1;
    logic       rd_uart;
    logic       key_rd = 1'b0;
    logic [3:0] key_out;
    logic       key_valid;
    logic       turbo_button;
    logic [2:0] fifo_count;
    logic [7:0] drop_count;

    uart_key_decoder #(.FIFO_DEPTH(DEPTH), .HOLDOFF(HOLD), .CASE_INS(1), .NO_REVERSE(1)) dut (
        .clk(clk), .rst(rst), .r_data(r_data), .rx_empty(rx_empty), .rd_uart(rd_uart),
        .key_rd(key_rd), .key_out(key_out), .key_valid(key_valid), .turbo_button(turbo_button),
        .fifo_count(fifo_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    logic [3:0] q[$];
    logic [3:0] m_last = 4'b0000;
    int         m_last_t = 0;
    logic       m_turbo = 1'b0;
    int         m_drop = 0;

    function automatic logic [3:0] key_of(input logic [7:0] b);
        case (b)
            "w", "W": return 4'b0001;
            "s", "S": return 4'b0010;
            "a", "A": return 4'b0100;
            "d", "D": return 4'b1000;
            default:  return 4'b0000;
        endcase
    endfunction

    function automatic bit opposite(input logic [3:0] x, input logic [3:0] y);
        return (x | y) == 4'b0011 || (x | y) == 4'b1100;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rd_uart"}, 32'(rd_uart), 32'(0));
        chk({tag, ".key_valid"}, 32'(key_valid), 32'(q.size() != 0));
        chk({tag, ".key_out"}, 32'(key_out), 32'(q.size() != 0 ? q[0] : 4'b0000));
        chk({tag, ".fifo_count"}, 32'(fifo_count), 32'(q.size()));
        chk({tag, ".drop_count"}, 32'(drop_count), 32'(m_drop));
        chk({tag, ".turbo"}, 32'(turbo_button), 32'(m_turbo));
    endtask

    task automatic model_reset();
        q.delete();
        m_last = 4'b0000;
        m_turbo = 1'b0;
        m_drop = 0;
    endtask

    // Applies one decoded byte at its push edge; cyc is the edge count just after that edge.
    task automatic model_push(input logic [7:0] b, input bit p);
        logic [3:0] k;
        bit rep, rev;
        k = key_of(b);
        if (p && q.size() != 0) void'(q.pop_front());
        if (b == 8'h20) m_turbo = ~m_turbo;
        if (k != 4'b0000) begin
            rep = k == m_last && (cyc - m_last_t) <= HOLD;
            rev = opposite(k, m_last);
            if (!rep && !rev) begin
                if (q.size() == DEPTH) m_drop = m_drop == 255 ? 255 : m_drop + 1;
                else begin
                    q.push_back(k);
                    m_last = k;
                    m_last_t = cyc;
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit p, input string tag);
        r_data = b;
        rx_empty = 1'b0;
        key_rd = 1'b0;
        @(negedge clk);
        rx_empty = 1'b1;
        chk({tag, ".rd_pulse"}, 32'(rd_uart), 32'(1));
        key_rd = p;
        @(negedge clk);
        key_rd = 1'b0;
        model_push(b, p);
        check_all(tag);
    endtask

    task automatic pop_key(input string tag);
        key_rd = 1'b1;
        @(negedge clk);
        key_rd = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
        check_all(tag);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        check_all(tag);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] tbl [12];
        tbl = '{"w", "s", "a", "d", "W", "S", "A", "D", 8'h20, "x", 8'h00, 8'h00};
        idle(2);
        do_reset("reset");

        send_byte("w", 1'b0, "w_single");
        pop_key("w_pop");
        pop_key("pop_empty");

        send_byte("d", 1'b0, "dd_first");
        send_byte("d", 1'b0, "dd_repeat");
        idle(HOLD + 2);
        send_byte("d", 1'b0, "dd_after_hold");

        do_reset("reset2");
        send_byte("w", 1'b0, "rev_w");
        send_byte("s", 1'b0, "rev_s");
        do_reset("reset3");
        send_byte("w", 1'b0, "perp_w");
        send_byte("a", 1'b0, "perp_a");

        do_reset("reset4");
        send_byte(8'h20, 1'b0, "space1");
        send_byte("x", 1'b0, "x_ignored");
        send_byte("D", 1'b0, "upper_d");
        send_byte(8'h20, 1'b0, "space2");

        // held-low rx_empty: one byte consumed per two cycles
        r_data = "x";
        rx_empty = 1'b0;
        @(negedge clk); chk("stream.rd1", 32'(rd_uart), 32'(1));
        @(negedge clk); chk("stream.rd0", 32'(rd_uart), 32'(0));
        @(negedge clk); chk("stream.rd2", 32'(rd_uart), 32'(1));
        rx_empty = 1'b1;
        @(negedge clk);
        check_all("stream_end");

        do_reset("reset5");
        foreach (tbl[i]) if (i < 6) begin
            send_byte(i % 2 == 0 ? 8'h77 : 8'h61, 1'b0, "fill");
            idle(HOLD + 2);
        end
        chk("full.count", 32'(fifo_count), 32'(4));
        chk("full.drops", 32'(drop_count), 32'(2));
        chk("full.head", 32'(key_out), 32'(4'b0001));
        send_byte("s", 1'b1, "full_push_pop");

        r_data = "w";
        rx_empty = 1'b0;
        @(negedge clk);
        rx_empty = 1'b1;
        chk("abort.rd", 32'(rd_uart), 32'(1));
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        check_all("abort_reset");
        rst = 1'b0;

        for (int i = 0; i < 4; i++) send_byte(i % 2 == 0 ? 8'h77 : 8'h61, 1'b0, "sat_fill");
        for (int i = 0; i < 260; i++) send_byte("w", 1'b0, "sat");

        do_reset("reset6");
        for (int i = 0; i < 120; i++) begin
            int sel;
            logic [7:0] b;
            sel = $urandom_range(0, 11);
            b = sel >= 10 ? 8'($urandom) : tbl[sel];
            send_byte(b, $urandom_range(0, 3) == 0, "rand");
            if ($urandom_range(0, 4) == 0) pop_key("rand_pop");
            idle($urandom_range(0, 12));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
